// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  function automatic int calc_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted;

  // rem_in[WIDTH-1] is the implicit carry out of the shift; if set, the
  // shifted value always exceeds the divisor and the modular subtract is exact.
  assign shifted = {rem_in[WIDTH-2:0], bit_in};
  assign q_bit   = rem_in[WIDTH-1] | (shifted >= divisor);
  assign rem_out = q_bit ? (shifted - divisor) : shifted;

endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned restoring divider, BITS_PER_CYCLE quotient bits per clock.
// Optional DIV_ZERO_FLAG_EN: adds div_zero port and a fast divide-by-zero path.
//
// state | meaning
// IDLE  | ready, waiting for start
// CALC  | restoring steps, step_cnt counts down to 0
// FIXUP | apply result signs, load output registers
// DONE  | done pulse for one cycle
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int N     = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(N);

  div_state_t state_q, state_d;

  logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
  logic [CNT_W-1:0] step_cnt;
  logic             neg_quo_q, neg_rem_q;

  logic             dvd_neg, dvs_neg, dvs_zero;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  logic [WIDTH-1:0]          rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] q_bits;

  assign dvd_neg  = is_signed & dividend[WIDTH-1];
  assign dvs_neg  = is_signed & divisor[WIDTH-1];
  assign dvs_zero = (divisor == '0);
  assign dvd_mag  = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign dvs_mag  = dvs_neg ? (~divisor + 1'b1) : divisor;

  assign rem_chain[0] = rem_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_chain[i]),
      .divisor (dvs_q),
      .bit_in  (quo_q[WIDTH-1-i]),
      .rem_out (rem_chain[i+1]),
      .q_bit   (q_bits[BITS_PER_CYCLE-1-i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
`ifdef DIV_ZERO_FLAG_EN
          state_d = dvs_zero ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (step_cnt == '0) state_d = FIXUP;
      FIXUP:   state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      step_cnt  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          quo_q     <= dvd_mag;
          rem_q     <= '0;
          dvs_q     <= dvs_mag;
          step_cnt  <= CNT_W'(N - 1);
          // A zero divisor must leave the all-ones quotient untouched.
          neg_quo_q <= (dvd_neg ^ dvs_neg) & ~dvs_zero;
          neg_rem_q <= dvd_neg;
`ifdef DIV_ZERO_FLAG_EN
          div_zero  <= dvs_zero;
          if (dvs_zero) begin
            quotient  <= '0;
            remainder <= dividend;
          end
`endif
        end
        CALC: begin
          quo_q <= {quo_q[WIDTH-BITS_PER_CYCLE-1:0], q_bits};
          rem_q <= rem_chain[BITS_PER_CYCLE];
          if (step_cnt != '0) step_cnt <= step_cnt - 1'b1;
        end
        FIXUP: begin
          quotient  <= neg_quo_q ? (~quo_q + 1'b1) : quo_q;
          remainder <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: default 32/1 instance plus a 16/4 instance.
// Honours DIV_ZERO_FLAG_EN when defined.
module tb_iter_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start1, signed1;
  logic [31:0] dvd1, dvs1, quo1, rem1;
  logic        ready1, done1;
  logic        start2, signed2;
  logic [15:0] dvd2, dvs2, quo2, rem2;
  logic        ready2, done2;
`ifdef DIV_ZERO_FLAG_EN
  logic        dz1, dz2;
  localparam bit DZ_EN = 1'b1;
`else
  logic        dz1, dz2;
  localparam bit DZ_EN = 1'b0;
  assign dz1 = 1'b0;
  assign dz2 = 1'b0;
`endif

  iter_divider u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .is_signed(signed1),
    .dividend(dvd1), .divisor(dvs1), .ready(ready1), .done(done1),
    .quotient(quo1), .remainder(rem1)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero(dz1)
`endif
  );

  iter_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .is_signed(signed2),
    .dividend(dvd2), .divisor(dvs2), .ready(ready2), .done(done2),
    .quotient(quo2), .remainder(rem2)
`ifdef DIV_ZERO_FLAG_EN
    , .div_zero(dz2)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb1[$];
  exp_t sb2[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_rdy1 = 0;
  exp_t m1, m2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_rdy1) begin
      check("ready_after_done", 64'(ready1), 64'(1));
      chk_rdy1 = 0;
    end
    if (reset && done1) begin
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        m1 = sb1.pop_front();
        check({m1.name, "_quotient"}, 64'(quo1), 64'(m1.q));
        check({m1.name, "_remainder"}, 64'(rem1), 64'(m1.r));
        check({m1.name, "_latency"}, 64'(cyc - m1.start_cyc + 1), 64'(m1.lat));
        if (DZ_EN) check({m1.name, "_div_zero"}, 64'(dz1), 64'(m1.dz));
        chk_rdy1 = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && done2) begin
      if (sb2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_unexpected_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        m2 = sb2.pop_front();
        check({m2.name, "_quotient"}, 64'(quo2), 64'(m2.q));
        check({m2.name, "_remainder"}, 64'(rem2), 64'(m2.r));
        check({m2.name, "_latency"}, 64'(cyc - m2.start_cyc + 1), 64'(m2.lat));
      end
    end
  end

  task automatic push1(input string name, input logic [31:0] q, input logic [31:0] r,
                       input logic dz, input int lat);
    exp_t e;
    e.name = name; e.q = q; e.r = r; e.dz = dz; e.start_cyc = cyc + 1; e.lat = lat;
    sb1.push_back(e);
  endtask

  task automatic issue1(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                        input logic dz, input int lat);
    int guard = 0;
    while (!ready1 && guard < 200) begin @(negedge clk); guard++; end
    if (!ready1) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: got ready=0 expected ready=1 within 200 cycles", name);
      return;
    end
    signed1 = s; dvd1 = a; dvs1 = b; start1 = 1'b1;
    push1(name, q, r, dz, lat);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic issue2(input string name, input logic s, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] q, input logic [15:0] r);
    exp_t e;
    int guard = 0;
    while (!ready2 && guard < 200) begin @(negedge clk); guard++; end
    if (!ready2) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout: got ready=0 expected ready=1 within 200 cycles", name);
      return;
    end
    signed2 = s; dvd2 = a; dvs2 = b; start2 = 1'b1;
    e.name = name; e.q = 32'(q); e.r = 32'(r); e.dz = 1'b0; e.start_cyc = cyc + 1; e.lat = 6;
    sb2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while ((sb1.size() != 0 || sb2.size() != 0) && guard < 300) begin
      @(negedge clk); guard++;
    end
    if (sb1.size() != 0 || sb2.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", name, sb1.size() + sb2.size());
      sb1.delete(); sb2.delete();
    end
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected normal completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset = 1'b0;
    start1 = 0; signed1 = 0; dvd1 = '0; dvs1 = '0;
    start2 = 0; signed2 = 0; dvd2 = '0; dvs2 = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready1), 64'(1));
    check("rst_done", 64'(done1), 64'(0));
    check("rst_quotient", 64'(quo1), 64'(0));
    check("rst_remainder", 64'(rem1), 64'(0));
    if (DZ_EN) check("rst_div_zero", 64'(dz1), 64'(0));
    reset = 1'b1;
    @(negedge clk);

    issue1("u_100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 34);
    issue1("u_big_lt", 0, 32'hFE8BACDE, 32'hFFFFEDCA, 32'h0, 32'hFE8BACDE, 0, 34);
    // -24400674 / -4662 = 5233 r -4428
    issue1("s_both_neg", 1, 32'hFE8BACDE, 32'hFFFFEDCA, 32'h00001471, 32'hFFFFEEB4, 0, 34);
    issue1("s_m7_2", 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 34);
    issue1("s_7_m2", 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 34);
    issue1("s_m100_m7", 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 0, 34);
    issue1("s_min_m1", 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 0, 34);
    issue1("u_max_1", 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0, 0, 34);
    issue1("u_max_16", 0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 0, 34);
    if (DZ_EN) begin
      issue1("u_dz", 0, 32'h1234, 32'h0, 32'h0, 32'h1234, 1, 1);
      issue1("s_dz_neg", 1, 32'hFFFFFFF0, 32'h0, 32'h0, 32'hFFFFFFF0, 1, 1);
    end else begin
      issue1("u_dz", 0, 32'h1234, 32'h0, 32'hFFFFFFFF, 32'h1234, 0, 34);
      issue1("s_dz_neg", 1, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF0, 0, 34);
    end
    issue1("u_after_dz", 0, 32'd50, 32'd5, 32'd10, 32'd0, 0, 34);
    drain("phase1");

    // Abort a division at its tenth cycle; start seen during reset must be ignored.
    issue1("aborted", 0, 32'd1000, 32'd3, 32'd333, 32'd1, 0, 34);
    t0 = cyc;
    while (cyc < t0 + 9) @(negedge clk);
    reset = 1'b0;
    start1 = 1'b1; dvd1 = 32'd9; dvs1 = 32'd2;
    @(negedge clk);
    sb1.delete();
    start1 = 1'b0;
    check("abort_ready", 64'(ready1), 64'(1));
    check("abort_done", 64'(done1), 64'(0));
    check("abort_quotient", 64'(quo1), 64'(0));
    check("abort_remainder", 64'(rem1), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("start_in_reset_ignored", 64'(ready1), 64'(1));
    repeat (40) @(negedge clk);
    issue1("u_3_3", 0, 32'd3, 32'd3, 32'd1, 32'd0, 0, 34);
    drain("phase2");

    issue2("w16_ffff_10", 0, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F);
    issue2("w16_s_min_m1", 1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000);
    drain("phase3");

    // Start held high: accepts every 7 cycles, never in the DONE cycle.
    signed2 = 0; dvd2 = 16'd200; dvs2 = 16'd7; start2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.name = $sformatf("w16_held_%0d", k);
      e.q = 32'd28; e.r = 32'd4; e.dz = 1'b0; e.start_cyc = cyc + 1 + 7 * k; e.lat = 6;
      sb2.push_back(e);
    end
    repeat (21) @(negedge clk);
    start2 = 1'b0;
    drain("phase4");
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
